// File: rtl/rpn_pkg.sv
// rtl/rpn_pkg.sv - shared types and constants for the RPN result print path
// Purpose : sequencer state encoding, ASCII constants and default sizing.
// Ports   : none (package).
package rpn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_COLLECT = 3'd2,
    ST_SKIP    = 3'd3,
    ST_EMIT    = 3'd4,
    ST_ERR     = 3'd5,
    ST_CR      = 3'd6,
    ST_LF      = 3'd7
  } seq_state_t;

  localparam logic [7:0] CHR_0  = 8'h30;
  localparam logic [7:0] CHR_E  = 8'h45;
  localparam logic [7:0] CHR_Q  = 8'h3F;
  localparam logic [7:0] CHR_CR = 8'h0D;
  localparam logic [7:0] CHR_LF = 8'h0A;

  localparam int DIGITS_DEF  = 5;
  localparam int TIMEOUT_DEF = 16;

  // States in which a byte is presented to the UART transmitter.
  function automatic logic is_tx_state(input seq_state_t s);
    return (s == ST_EMIT) || (s == ST_ERR) || (s == ST_CR) || (s == ST_LF);
  endfunction

endpackage

// File: rtl/bcd_to_ascii.sv
// rtl/bcd_to_ascii.sv - combinational BCD digit to ASCII character
// Purpose : maps 0..9 to '0'..'9'; any non-decimal code maps to '?'.
// Ports   : i_bcd   in  4  BCD digit
//           o_ascii out 8  ASCII character
module bcd_to_ascii
  import rpn_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [7:0] o_ascii
);

  assign o_ascii = (i_bcd > 4'd9) ? CHR_Q : (CHR_0 + {4'h0, i_bcd});

endmodule

// File: rtl/result_tx_sequencer.sv
// rtl/result_tx_sequencer.sv - prints one 16-bit RPN result over UART TX
// Purpose : accepts a result, drives the decimal encoder, captures its digit
//           stream, drops leading zeros and sends ASCII digits then CR LF.
//           Error results (or an encoder that never answers) print "E".
// Ports   : clk, rst_n                  clock, async active-low reset
//           res_valid/res_ready/res_data/res_err   result handshake
//           enc_din/enc_wen             encoder request (registered)
//           enc_dout/enc_sending        encoder digit stream, MS digit first
//           tx_data/tx_valid/tx_ready   byte stream to the UART transmitter
module result_tx_sequencer
  import rpn_pkg::*;
#(
  parameter int DIGITS  = DIGITS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [15:0] res_data,
  input  logic        res_err,
  output logic [15:0] enc_din,
  output logic        enc_wen,
  input  logic [3:0]  enc_dout,
  input  logic        enc_sending,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  seq_state_t    r_state;
  seq_state_t    w_next_state;

  logic [3:0]    r_buf [DIGITS];
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_ptr;
  logic [CW-1:0] w_ptr_nxt;
  logic [TW-1:0] r_tmo;

  logic          r_res_ready;
  logic [15:0]   r_enc_din;
  logic          r_enc_wen;
  logic [7:0]    r_tx_data;
  logic          r_tx_valid;

  logic          w_res_ready_d;
  logic          w_enc_wen_d;
  logic [7:0]    w_tx_data_d;
  logic          w_tx_valid_d;

  logic          w_accept;
  logic          w_tx_fire;
  logic          w_last;
  logic [3:0]    w_cur_digit;
  logic [3:0]    w_sel_digit;
  logic [7:0]    w_sel_ascii;

  assign w_accept    = res_valid & r_res_ready;
  assign w_tx_fire   = r_tx_valid & tx_ready;
  assign w_last      = ((r_ptr + CW'(1)) == r_cnt);
  assign w_cur_digit = r_buf[r_ptr[IW-1:0]];
  // The registered tx_data is computed from the pointer of the next cycle so
  // the byte on the wire always matches the digit the FSM is presenting.
  assign w_sel_digit = r_buf[w_ptr_nxt[IW-1:0]];

  bcd_to_ascii u_bcd_to_ascii (
    .i_bcd   (w_sel_digit),
    .o_ascii (w_sel_ascii)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and digit pointer
  always_comb begin
    w_next_state = r_state;
    w_ptr_nxt    = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = res_err ? ST_ERR : ST_START;
        end
      end
      ST_START: begin
        if (enc_sending) begin
          w_next_state = ST_COLLECT;
        end else if (r_tmo == TW'(TIMEOUT - 1)) begin
          w_next_state = ST_ERR;
        end
      end
      ST_COLLECT: begin
        if (!enc_sending) begin
          w_next_state = ST_SKIP;
          w_ptr_nxt    = '0;
        end
      end
      ST_SKIP: begin
        // The last captured digit is never skipped, so zero prints "0".
        if (r_cnt == '0) begin
          w_next_state = ST_ERR;
        end else if ((w_cur_digit == 4'd0) && !w_last) begin
          w_ptr_nxt = r_ptr + CW'(1);
        end else begin
          w_next_state = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (w_tx_fire) begin
          if (w_last) begin
            w_next_state = ST_CR;
          end else begin
            w_ptr_nxt = r_ptr + CW'(1);
          end
        end
      end
      ST_ERR: begin
        if (w_tx_fire) w_next_state = ST_CR;
      end
      ST_CR: begin
        if (w_tx_fire) w_next_state = ST_LF;
      end
      ST_LF: begin
        if (w_tx_fire) w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Output decode, registered below
  always_comb begin
    w_res_ready_d = (w_next_state == ST_IDLE);
    w_enc_wen_d   = (r_state == ST_IDLE) && w_accept && !res_err;
    w_tx_valid_d  = is_tx_state(w_next_state);
    case (w_next_state)
      ST_EMIT: w_tx_data_d = w_sel_ascii;
      ST_ERR:  w_tx_data_d = CHR_E;
      ST_CR:   w_tx_data_d = CHR_CR;
      ST_LF:   w_tx_data_d = CHR_LF;
      default: w_tx_data_d = 8'h00;
    endcase
  end

  // Datapath: registered outputs, digit capture, timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_ready <= 1'b0;
      r_enc_din   <= '0;
      r_enc_wen   <= 1'b0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_tmo       <= '0;
      for (int i = 0; i < DIGITS; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_res_ready <= w_res_ready_d;
      r_enc_wen   <= w_enc_wen_d;
      r_tx_valid  <= w_tx_valid_d;
      r_tx_data   <= w_tx_data_d;
      r_ptr       <= w_ptr_nxt;

      if ((r_state == ST_IDLE) && w_accept) begin
        r_enc_din <= res_data;
      end

      if (r_state == ST_START) begin
        r_tmo <= r_tmo + TW'(1);
      end else begin
        r_tmo <= '0;
      end

      // The digit present on the cycle enc_sending is first seen in START
      // is captured too; digits beyond DIGITS are dropped.
      if (r_state == ST_IDLE) begin
        r_cnt <= '0;
      end else if (((r_state == ST_START) || (r_state == ST_COLLECT)) &&
                   enc_sending && (r_cnt < CW'(DIGITS))) begin
        r_buf[r_cnt[IW-1:0]] <= enc_dout;
        r_cnt                <= r_cnt + CW'(1);
      end
    end
  end

  assign res_ready = r_res_ready;
  assign enc_din   = r_enc_din;
  assign enc_wen   = r_enc_wen;
  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;

endmodule

// File: tb/tb_result_tx_sequencer.sv
// tb/tb_result_tx_sequencer.sv - self-checking bench for result_tx_sequencer
module tb_result_tx_sequencer;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst_n;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_err;
  logic [15:0] enc_din;
  logic        enc_wen;
  logic [3:0]  enc_dout;
  logic        enc_sending;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int ready_mode = 0;   // 0: always ready, 1: 0,0,1 per byte, 2: random
  bit enc_dead = 0;     // encoder stub never raises enc_sending
  int wen_cnt = 0;
  int wen_base = 0;
  logic [15:0] wen_din = '0;
  int wen_cyc = 0;
  int first_valid_cyc = -1;
  int stab_viol = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  result_tx_sequencer #(.DIGITS(5), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_err     (res_err),
    .enc_din     (enc_din),
    .enc_wen     (enc_wen),
    .enc_dout    (enc_dout),
    .enc_sending (enc_sending),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Decimal encoder model: one cycle after the write-enable pulse it streams
  // all five digits of the value, most significant first (leading zeros kept).
  initial begin
    int t;
    logic [3:0] d [5];
    enc_sending = 1'b0;
    enc_dout    = 4'd0;
    forever begin
      @(negedge clk);
      if (enc_wen === 1'b1 && !enc_dead) begin
        t = int'(enc_din);
        for (int i = 4; i >= 0; i--) begin
          d[i] = 4'(t % 10);
          t = t / 10;
        end
        @(posedge clk);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
          #1;
          enc_sending = 1'b1;
          enc_dout    = d[i];
          @(posedge clk);
        end
        #1;
        enc_sending = 1'b0;
        enc_dout    = 4'd0;
      end
    end
  end

  // Transmitter model and monitor: decides tx_ready for the coming edge and
  // records each byte that edge will accept.
  initial begin
    int  hold;
    bit  stalled;
    bit  r;
    logic [7:0] stall_data;
    hold = 0;
    stalled = 0;
    stall_data = 8'h00;
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (enc_wen === 1'b1) begin
        wen_cnt = wen_cnt + 1;
        wen_din = enc_din;
        wen_cyc = cyc;
      end
      if (tx_valid === 1'b1) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (stalled && tx_data !== stall_data) stab_viol = stab_viol + 1;
        case (ready_mode)
          0:       r = 1'b1;
          1:       r = (hold >= 2);
          default: r = 1'($urandom_range(0, 1));
        endcase
        tx_ready = r;
        if (r) begin
          rx_q.push_back(tx_data);
          hold = 0;
          stalled = 0;
        end else begin
          hold = hold + 1;
          stalled = 1;
          stall_data = tx_data;
        end
      end else begin
        tx_ready = (ready_mode == 0);
        hold = 0;
        stalled = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: decimal text of the value without leading zeros, or "E".
  function automatic void build_exp(input logic [15:0] v, input logic e);
    int t;
    exp_q.delete();
    if (e) begin
      exp_q.push_back(8'h45);
    end else begin
      t = int'(v);
      if (t == 0) exp_q.push_back(8'h30);
      while (t > 0) begin
        exp_q.push_front(8'(48 + t % 10));
        t = t / 10;
      end
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  task automatic run_one(input logic [15:0] v, input logic e, output bit to);
    int n;
    build_exp(v, e);
    rx_q.delete();
    wen_base = wen_cnt;
    first_valid_cyc = -1;
    n = 0;
    while (res_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    res_data  = v;
    res_err   = e;
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    n = 0;
    while (rx_q.size() < exp_q.size() && n < 3000) begin
      @(negedge clk);
      n++;
    end
    to = (n >= 3000);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    res_valid = 1'b0;
    res_data = '0;
    res_err = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL reset_res_ready: got %b expected 0", res_ready); end
    checks++; if (enc_din !== 16'h0) begin errors++; $display("FAIL reset_enc_din: got %h expected 0000", enc_din); end
    checks++; if (enc_wen !== 1'b0) begin errors++; $display("FAIL reset_enc_wen: got %b expected 0", enc_wen); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_rise: got %b expected 1", res_ready); end
  endtask

  task automatic test_basic();
    bit to;
    ready_mode = 0;
    run_one(16'd123, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout: got %0d bytes expected %0d", rx_q.size(), exp_q.size()); end
    checks++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_len: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_byte[%0d]: got %h expected %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]); end
    end
    checks++; if (wen_cnt - wen_base !== 1) begin errors++; $display("FAIL basic_wen_pulses: got %0d expected 1", wen_cnt - wen_base); end
    checks++; if (wen_din !== 16'd123) begin errors++; $display("FAIL basic_enc_din: got %0d expected 123", wen_din); end
    checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after: got %b expected 1", res_ready); end
  endtask

  task automatic test_values();
    bit to;
    logic [15:0] vals [3];
    vals[0] = 16'd65535;
    vals[1] = 16'd0;
    vals[2] = 16'd10000;
    ready_mode = 0;
    for (int k = 0; k < 3; k++) begin
      run_one(vals[k], 1'b0, to);
      checks++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL value_%0d_len: got %0d expected %0d", vals[k], rx_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL value_%0d_byte[%0d]: got %h expected %h", vals[k], i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]); end
      end
    end
  endtask

  task automatic test_err();
    bit to;
    ready_mode = 0;
    run_one(16'($urandom), 1'b1, to);
    checks++; if (rx_q.size() !== 3) begin errors++; $display("FAIL err_len: got %0d expected 3", rx_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL err_byte[%0d]: got %h expected %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]); end
    end
    checks++; if (wen_cnt - wen_base !== 0) begin errors++; $display("FAIL err_wen_pulses: got %0d expected 0", wen_cnt - wen_base); end
  endtask

  task automatic test_timeout();
    bit to;
    int gap;
    ready_mode = 0;
    enc_dead = 1;
    run_one(16'd123, 1'b0, to);
    build_exp(16'd0, 1'b1);
    gap = first_valid_cyc - wen_cyc;
    checks++; if (rx_q.size() !== 3) begin errors++; $display("FAIL timeout_len: got %0d expected 3", rx_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL timeout_byte[%0d]: got %h expected %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]); end
    end
    checks++; if (wen_cnt - wen_base !== 1) begin errors++; $display("FAIL timeout_wen_pulses: got %0d expected 1", wen_cnt - wen_base); end
    checks++; if (gap < TIMEOUT || gap > TIMEOUT + 1) begin errors++; $display("FAIL timeout_wait: got %0d cycles expected %0d..%0d", gap, TIMEOUT, TIMEOUT + 1); end
    enc_dead = 0;
  endtask

  task automatic test_stall();
    bit to;
    int n_before;
    ready_mode = 1;
    stab_viol = 0;
    fork
      run_one(16'd123, 1'b0, to);
      begin
        repeat (4) @(negedge clk);
        for (int k = 0; k < 60; k++) begin
          @(negedge clk);
          if (res_ready === 1'b0 && rx_q.size() < 4) begin
            res_data  = 16'd999;
            res_valid = 1'b1;
            @(negedge clk);
            res_valid = 1'b0;
          end
        end
      end
    join
    checks++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL stall_len: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_byte[%0d]: got %h expected %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]); end
    end
    checks++; if (stab_viol !== 0) begin errors++; $display("FAIL stall_stable: got %0d changes expected 0", stab_viol); end
    checks++; if (wen_cnt - wen_base !== 1) begin errors++; $display("FAIL stall_wen_pulses: got %0d expected 1", wen_cnt - wen_base); end
    n_before = rx_q.size();
    repeat (40) @(negedge clk);
    checks++; if (rx_q.size() !== n_before) begin errors++; $display("FAIL stall_extra_print: got %0d bytes expected %0d", rx_q.size(), n_before); end
    checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_after: got %b expected 1", res_ready); end
  endtask

  task automatic test_reset_mid();
    bit to;
    int n;
    ready_mode = 0;
    rx_q.delete();
    n = 0;
    while (res_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    res_data  = 16'd65535;
    res_err   = 1'b0;
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    n = 0;
    while (rx_q.size() < 2 && n < 500) begin @(negedge clk); n++; end
    checks++; if (n >= 500) begin errors++; $display("FAIL midrst_reach_emit: got %0d bytes expected 2", rx_q.size()); end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL midrst_tx_valid: got %b expected 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL midrst_tx_data: got %h expected 00", tx_data); end
    checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL midrst_res_ready: got %b expected 0", res_ready); end
    checks++; if (enc_din !== 16'h0) begin errors++; $display("FAIL midrst_enc_din: got %h expected 0000", enc_din); end
    checks++; if (enc_wen !== 1'b0) begin errors++; $display("FAIL midrst_enc_wen: got %b expected 0", enc_wen); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    run_one(16'd7, 1'b0, to);
    checks++; if (rx_q.size() !== 3) begin errors++; $display("FAIL midrst_len: got %0d expected 3", rx_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_byte[%0d]: got %h expected %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]); end
    end
  endtask

  task automatic test_random();
    bit to;
    logic [15:0] v;
    logic e;
    ready_mode = 2;
    stab_viol = 0;
    for (int k = 0; k < 10; k++) begin
      v = 16'($urandom);
      if ($urandom_range(0, 3) == 0) v = 16'($urandom_range(0, 99));
      e = ($urandom_range(0, 7) == 0);
      run_one(v, e, to);
      checks++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL random_%0d_len: got %0d expected %0d", v, rx_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_%0d_byte[%0d]: got %h expected %h", v, i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]); end
      end
      checks++; if (wen_cnt - wen_base !== (e ? 0 : 1)) begin errors++; $display("FAIL random_%0d_wen: got %0d expected %0d", v, wen_cnt - wen_base, e ? 0 : 1); end
    end
    checks++; if (stab_viol !== 0) begin errors++; $display("FAIL random_stable: got %0d changes expected 0", stab_viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_err();
    test_timeout();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
